// File: rtl/cmos_video_checker.sv
// Receiver-side checker for a parallel CMOS video stream (fv/lv/dvalid/data).
// Decodes frame and line structure, counts pixels/lines/frames, sums each
// frame's pixels and raises sticky protocol errors against the fixed geometry.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_SYNC  | after reset; wait for fv low so a partial frame is dropped
// ST_IDLE  | between frames; wait for fv rising
// ST_FRAME | inside fv, between lines
// ST_LINE  | inside lv; accepted pixels are counted and summed
//
// Pipeline: inputs -> S1 registers -> FSM/event registers -> output registers.
// A close pulse appears two clocks after the edge that first samples the
// falling fv/lv, together with its latched counts and checksum.
module cmos_video_checker #(
  parameter int DWIDTH         = 10,
  parameter int EXP_PIXELS     = 1000,
  parameter int EXP_LINES      = 4,
  parameter int LONG_EVEN_LINE = 0
) (
  input  logic              pix_clk_i,
  input  logic              reset_n_i,
  input  logic              fv_i,
  input  logic              lv_i,
  input  logic              dvalid_i,
  input  logic [DWIDTH-1:0] pixdata_i,
  input  logic              clr_i,
  output logic [15:0]       frame_cnt_o,
  output logic [15:0]       last_line_cnt_o,
  output logic [15:0]       last_pix_cnt_o,
  output logic [31:0]       checksum_o,
  output logic              frame_done_o,
  output logic              line_done_o,
  output logic [3:0]        err_o
);

  localparam logic [15:0] CNT_MAX  = 16'hFFFF;
  localparam logic [15:0] EXP_PIX  = 16'(EXP_PIXELS);
  localparam logic [15:0] EXP_PIX2 = 16'(2 * EXP_PIXELS);
  localparam logic [15:0] EXP_LN   = 16'(EXP_LINES);

  typedef enum logic [1:0] {ST_SYNC, ST_IDLE, ST_FRAME, ST_LINE} state_t;

  state_t            state, state_n;
  logic              fv_s1, lv_s1, dv_s1, s1_vld;
  logic              fv_p, lv_p;
  logic [DWIDTH-1:0] pd_s1;

  logic [15:0] pix_cnt, pix_n, line_cnt, line_n;
  logic [31:0] run_sum, sum_n;

  logic        line_close, frame_close;
  logic [3:0]  err_set;
  logic [15:0] pix_inc, line_inc, exp_len;
  logic [31:0] pix_ext;
  logic        fv_rise, fv_fall, lv_rise, lv_fall, acc;

  logic        ev_line, ev_frame;
  logic [15:0] ev_pix, ev_lines;
  logic [31:0] ev_sum;
  logic [3:0]  ev_err;
  logic [15:0] frame_base;

  // S1 input capture plus previous-S1 copy for edge detection; s1_vld marks
  // that S1 holds a real sample so SYNC does not exit on reset values.
  always_ff @(posedge pix_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      fv_s1  <= 1'b0;
      lv_s1  <= 1'b0;
      dv_s1  <= 1'b0;
      pd_s1  <= '0;
      fv_p   <= 1'b0;
      lv_p   <= 1'b0;
      s1_vld <= 1'b0;
    end else begin
      fv_s1  <= fv_i;
      lv_s1  <= lv_i;
      dv_s1  <= dvalid_i;
      pd_s1  <= pixdata_i;
      fv_p   <= fv_s1;
      lv_p   <= lv_s1;
      s1_vld <= 1'b1;
    end
  end

  assign fv_rise  = fv_s1 & ~fv_p;
  assign fv_fall  = ~fv_s1 & fv_p;
  assign lv_rise  = lv_s1 & ~lv_p;
  assign lv_fall  = ~lv_s1 & lv_p;
  assign acc      = lv_s1 & dv_s1;
  assign pix_ext  = 32'(pd_s1);
  assign pix_inc  = (pix_cnt == CNT_MAX) ? pix_cnt : pix_cnt + 16'd1;
  assign line_inc = (line_cnt == CNT_MAX) ? line_cnt : line_cnt + 16'd1;
  // line_cnt still holds the previous count, so an odd value means the
  // closing line has an even 1-based index.
  assign exp_len  = ((LONG_EVEN_LINE != 0) && line_cnt[0]) ? EXP_PIX2 : EXP_PIX;

  // Next-state, running counters and close/error events.
  always_comb begin
    state_n     = state;
    pix_n       = pix_cnt;
    line_n      = line_cnt;
    sum_n       = run_sum;
    line_close  = 1'b0;
    frame_close = 1'b0;
    err_set     = 4'b0000;
    case (state)
      ST_SYNC: begin
        if (s1_vld && !fv_s1) state_n = ST_IDLE;
      end
      ST_IDLE: begin
        if (fv_rise) begin
          line_n = 16'd0;
          sum_n  = 32'd0;
          if (lv_s1) begin
            state_n = ST_LINE;
            pix_n   = acc ? 16'd1 : 16'd0;
            sum_n   = acc ? pix_ext : 32'd0;
          end else begin
            state_n = ST_FRAME;
          end
        end
      end
      ST_FRAME: begin
        if (fv_fall) begin
          frame_close = 1'b1;
          state_n     = ST_IDLE;
        end else if (lv_rise) begin
          state_n = ST_LINE;
          pix_n   = acc ? 16'd1 : 16'd0;
          sum_n   = run_sum + (acc ? pix_ext : 32'd0);
        end
      end
      ST_LINE: begin
        if (fv_fall || lv_fall) begin
          line_close = 1'b1;
          line_n     = line_inc;
          if (fv_fall) begin
            frame_close = 1'b1;
            state_n     = ST_IDLE;
            if (lv_s1) err_set[3] = 1'b1;
          end else begin
            state_n = ST_FRAME;
          end
        end else if (acc) begin
          pix_n = pix_inc;
          sum_n = run_sum + pix_ext;
        end
      end
      default: state_n = ST_SYNC;
    endcase
    if (state != ST_SYNC && lv_rise && !fv_s1) err_set[2] = 1'b1;
    if (line_close && (pix_cnt != exp_len)) err_set[0] = 1'b1;
    if (frame_close && (line_n != EXP_LN)) err_set[1] = 1'b1;
  end

  // FSM state, running counters and the registered close events.
  always_ff @(posedge pix_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state    <= ST_SYNC;
      pix_cnt  <= 16'd0;
      line_cnt <= 16'd0;
      run_sum  <= 32'd0;
      ev_line  <= 1'b0;
      ev_frame <= 1'b0;
      ev_pix   <= 16'd0;
      ev_lines <= 16'd0;
      ev_sum   <= 32'd0;
      ev_err   <= 4'b0000;
    end else begin
      state    <= state_n;
      pix_cnt  <= pix_n;
      line_cnt <= line_n;
      run_sum  <= sum_n;
      ev_line  <= line_close;
      ev_frame <= frame_close;
      ev_err   <= err_set;
      if (line_close) ev_pix <= pix_cnt;
      if (frame_close) begin
        ev_lines <= line_n;
        ev_sum   <= run_sum;
      end
    end
  end

  // A clear and a frame close in the same cycle leave the count at one.
  assign frame_base = clr_i ? 16'd0 : frame_cnt_o;

  // Output stage: pulses, latched results, sticky errors, frame counter.
  always_ff @(posedge pix_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      frame_cnt_o     <= 16'd0;
      last_line_cnt_o <= 16'd0;
      last_pix_cnt_o  <= 16'd0;
      checksum_o      <= 32'd0;
      frame_done_o    <= 1'b0;
      line_done_o     <= 1'b0;
      err_o           <= 4'b0000;
    end else begin
      line_done_o  <= ev_line;
      frame_done_o <= ev_frame;
      err_o        <= (clr_i ? 4'b0000 : err_o) | ev_err;
      if (ev_line) last_pix_cnt_o <= ev_pix;
      if (ev_frame) begin
        last_line_cnt_o <= ev_lines;
        checksum_o      <= ev_sum;
      end
      if (ev_frame && frame_base != CNT_MAX) frame_cnt_o <= frame_base + 16'd1;
      else                                   frame_cnt_o <= frame_base;
    end
  end

endmodule

// File: tb/tb_cmos_video_checker.sv
module tb_cmos_video_checker;

  logic        pix_clk_i = 1'b0;
  logic        reset_n_i = 1'b0;
  logic        fv_i = 1'b0, lv_i = 1'b0, dvalid_i = 1'b0, clr_i = 1'b0;
  logic [9:0]  pixdata_i = '0;

  logic [15:0] frame_cnt, last_line_cnt, last_pix_cnt;
  logic [31:0] checksum;
  logic        frame_done, line_done;
  logic [3:0]  err;

  logic [15:0] l_frame_cnt, l_last_line_cnt, l_last_pix_cnt;
  logic [31:0] l_checksum;
  logic        l_frame_done, l_line_done;
  logic [3:0]  l_err;

  int checks = 0;
  int errors = 0;
  int line_pulses = 0, frame_pulses = 0, l_line_pulses = 0;

  always #5 pix_clk_i = ~pix_clk_i;

  cmos_video_checker #(.DWIDTH(10), .EXP_PIXELS(8), .EXP_LINES(4), .LONG_EVEN_LINE(0)) dut (
    .pix_clk_i(pix_clk_i), .reset_n_i(reset_n_i), .fv_i(fv_i), .lv_i(lv_i),
    .dvalid_i(dvalid_i), .pixdata_i(pixdata_i), .clr_i(clr_i),
    .frame_cnt_o(frame_cnt), .last_line_cnt_o(last_line_cnt), .last_pix_cnt_o(last_pix_cnt),
    .checksum_o(checksum), .frame_done_o(frame_done), .line_done_o(line_done), .err_o(err));

  cmos_video_checker #(.DWIDTH(10), .EXP_PIXELS(8), .EXP_LINES(4), .LONG_EVEN_LINE(1)) dut_l (
    .pix_clk_i(pix_clk_i), .reset_n_i(reset_n_i), .fv_i(fv_i), .lv_i(lv_i),
    .dvalid_i(dvalid_i), .pixdata_i(pixdata_i), .clr_i(clr_i),
    .frame_cnt_o(l_frame_cnt), .last_line_cnt_o(l_last_line_cnt), .last_pix_cnt_o(l_last_pix_cnt),
    .checksum_o(l_checksum), .frame_done_o(l_frame_done), .line_done_o(l_line_done), .err_o(l_err));

  // Pulse counters sampled away from the active edge.
  always @(negedge pix_clk_i) begin
    if (line_done)   line_pulses++;
    if (frame_done)  frame_pulses++;
    if (l_line_done) l_line_pulses++;
  end

  task automatic step(input logic f, input logic l, input logic d, input int p);
    fv_i = f; lv_i = l; dvalid_i = d; pixdata_i = p[9:0];
    @(posedge pix_clk_i); #1;
  endtask

  task automatic send_line(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b1, 1'b1, i);
    repeat (3) step(1'b1, 1'b0, 1'b0, 0);
  endtask

  task automatic frame4(input int a, input int b, input int c, input int d);
    repeat (2) step(1'b1, 1'b0, 1'b0, 0);
    send_line(a); send_line(b); send_line(c); send_line(d);
    repeat (4) step(1'b0, 1'b0, 1'b0, 0);
  endtask

  task automatic pulse_clr();
    clr_i = 1'b1;
    step(1'b0, 1'b0, 1'b0, 0);
    clr_i = 1'b0;
  endtask

  task automatic test_reset();
    reset_n_i = 1'b0;
    repeat (3) step(1'b0, 1'b0, 1'b0, 0);
    checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL rst_frame_cnt: got %0d expected 0", frame_cnt); end
    checks++; if (err !== 4'b0000) begin errors++; $display("FAIL rst_err: got %b expected 0000", err); end
    checks++; if (checksum !== 32'd0) begin errors++; $display("FAIL rst_checksum: got %0d expected 0", checksum); end
    checks++; if (last_line_cnt !== 16'd0 || last_pix_cnt !== 16'd0) begin errors++; $display("FAIL rst_last_cnts: got %0d/%0d expected 0/0", last_line_cnt, last_pix_cnt); end
    checks++; if (frame_done !== 1'b0 || line_done !== 1'b0) begin errors++; $display("FAIL rst_pulses: got %b/%b expected 0/0", frame_done, line_done); end
    reset_n_i = 1'b1;
    repeat (3) step(1'b0, 1'b0, 1'b0, 0);
  endtask

  task automatic test_nominal();
    int lb, fb;
    lb = line_pulses; fb = frame_pulses;
    frame4(8, 8, 8, 8);
    frame4(8, 8, 8, 8);
    checks++; if (line_pulses - lb !== 8) begin errors++; $display("FAIL nom_line_pulses: got %0d expected 8", line_pulses - lb); end
    checks++; if (frame_pulses - fb !== 2) begin errors++; $display("FAIL nom_frame_pulses: got %0d expected 2", frame_pulses - fb); end
    checks++; if (last_pix_cnt !== 16'd8) begin errors++; $display("FAIL nom_last_pix: got %0d expected 8", last_pix_cnt); end
    checks++; if (last_line_cnt !== 16'd4) begin errors++; $display("FAIL nom_last_line: got %0d expected 4", last_line_cnt); end
    checks++; if (checksum !== 32'd112) begin errors++; $display("FAIL nom_checksum: got %0d expected 112", checksum); end
    checks++; if (frame_cnt !== 16'd2) begin errors++; $display("FAIL nom_frame_cnt: got %0d expected 2", frame_cnt); end
    checks++; if (err !== 4'b0000) begin errors++; $display("FAIL nom_err: got %b expected 0000", err); end
  endtask

  task automatic test_short_line();
    repeat (2) step(1'b1, 1'b0, 1'b0, 0);
    send_line(8); send_line(8); send_line(7);
    checks++; if (err !== 4'b0001) begin errors++; $display("FAIL short_err_mid: got %b expected 0001", err); end
    checks++; if (last_pix_cnt !== 16'd7) begin errors++; $display("FAIL short_last_pix: got %0d expected 7", last_pix_cnt); end
    send_line(8);
    repeat (4) step(1'b0, 1'b0, 1'b0, 0);
    checks++; if (err !== 4'b0001) begin errors++; $display("FAIL short_err_end: got %b expected 0001", err); end
    checks++; if (checksum !== 32'd105) begin errors++; $display("FAIL short_checksum: got %0d expected 105", checksum); end
    checks++; if (frame_cnt !== 16'd3) begin errors++; $display("FAIL short_frame_cnt: got %0d expected 3", frame_cnt); end
    pulse_clr();
    checks++; if (err !== 4'b0000 || frame_cnt !== 16'd0) begin errors++; $display("FAIL clr: got err=%b frames=%0d expected 0000/0", err, frame_cnt); end
  endtask

  task automatic test_fv_drop();
    repeat (2) step(1'b1, 1'b0, 1'b0, 0);
    send_line(8);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b1, i);
    step(1'b0, 1'b1, 1'b0, 0);
    repeat (4) step(1'b0, 1'b0, 1'b0, 0);
    checks++; if (err !== 4'b1011) begin errors++; $display("FAIL drop_err: got %b expected 1011", err); end
    checks++; if (last_line_cnt !== 16'd2) begin errors++; $display("FAIL drop_last_line: got %0d expected 2", last_line_cnt); end
    checks++; if (last_pix_cnt !== 16'd4) begin errors++; $display("FAIL drop_last_pix: got %0d expected 4", last_pix_cnt); end
    checks++; if (checksum !== 32'd34) begin errors++; $display("FAIL drop_checksum: got %0d expected 34", checksum); end
    checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL drop_frame_cnt: got %0d expected 1", frame_cnt); end
    pulse_clr();
    repeat (2) step(1'b1, 1'b0, 1'b0, 0);
    send_line(8);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b1, i);
    repeat (4) step(1'b0, 1'b0, 1'b0, 0);
    checks++; if (err !== 4'b0011) begin errors++; $display("FAIL both_fall_err: got %b expected 0011", err); end
    checks++; if (last_line_cnt !== 16'd2) begin errors++; $display("FAIL both_fall_last_line: got %0d expected 2", last_line_cnt); end
  endtask

  task automatic test_long_even();
    int lb;
    pulse_clr();
    lb = l_line_pulses;
    frame4(8, 16, 8, 16);
    checks++; if (l_err !== 4'b0000) begin errors++; $display("FAIL long_err: got %b expected 0000", l_err); end
    checks++; if (l_checksum !== 32'd296) begin errors++; $display("FAIL long_checksum: got %0d expected 296", l_checksum); end
    checks++; if (l_last_pix_cnt !== 16'd16 || l_last_line_cnt !== 16'd4) begin errors++; $display("FAIL long_last_cnts: got %0d/%0d expected 16/4", l_last_pix_cnt, l_last_line_cnt); end
    checks++; if (l_line_pulses - lb !== 4 || l_frame_cnt !== 16'd1) begin errors++; $display("FAIL long_pulses: got lines=%0d frames=%0d expected 4/1", l_line_pulses - lb, l_frame_cnt); end
    pulse_clr();
    frame4(8, 8, 8, 16);
    checks++; if (l_err !== 4'b0001) begin errors++; $display("FAIL long_short_even_err: got %b expected 0001", l_err); end
    checks++; if (l_checksum !== 32'd204) begin errors++; $display("FAIL long_short_even_checksum: got %0d expected 204", l_checksum); end
  endtask

  task automatic test_reset_mid_frame();
    int lb, fb;
    pulse_clr();
    repeat (2) step(1'b1, 1'b0, 1'b0, 0);
    send_line(8);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, i);
    reset_n_i = 1'b0;
    repeat (2) step(1'b1, 1'b1, 1'b1, 3);
    reset_n_i = 1'b1;
    lb = line_pulses; fb = frame_pulses;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, i);
    repeat (3) step(1'b1, 1'b0, 1'b0, 0);
    send_line(8);
    repeat (4) step(1'b0, 1'b0, 1'b0, 0);
    checks++; if (line_pulses - lb !== 0 || frame_pulses - fb !== 0) begin errors++; $display("FAIL sync_pulses: got %0d/%0d expected 0/0", line_pulses - lb, frame_pulses - fb); end
    checks++; if (err !== 4'b0000 || frame_cnt !== 16'd0) begin errors++; $display("FAIL sync_state: got err=%b frames=%0d expected 0000/0", err, frame_cnt); end
    frame4(8, 8, 8, 8);
    checks++; if (frame_cnt !== 16'd1 || frame_pulses - fb !== 1) begin errors++; $display("FAIL sync_first_frame: got frames=%0d pulses=%0d expected 1/1", frame_cnt, frame_pulses - fb); end
    checks++; if (err !== 4'b0000) begin errors++; $display("FAIL sync_err: got %b expected 0000", err); end
  endtask

  task automatic test_lv_outside_fv();
    int lb;
    lb = line_pulses;
    repeat (3) step(1'b0, 1'b1, 1'b1, 5);
    repeat (3) step(1'b0, 1'b0, 1'b0, 0);
    checks++; if (err !== 4'b0100) begin errors++; $display("FAIL lv_out_err: got %b expected 0100", err); end
    checks++; if (frame_cnt !== 16'd1 || last_pix_cnt !== 16'd8) begin errors++; $display("FAIL lv_out_cnts: got frames=%0d pix=%0d expected 1/8", frame_cnt, last_pix_cnt); end
    checks++; if (line_pulses - lb !== 0) begin errors++; $display("FAIL lv_out_pulses: got %0d expected 0", line_pulses - lb); end
  endtask

  task automatic test_dvalid_gaps();
    pulse_clr();
    repeat (2) step(1'b1, 1'b0, 1'b0, 0);
    for (int ln = 0; ln < 4; ln++) begin
      for (int i = 0; i < 16; i++) step(1'b1, 1'b1, (i % 2) == 0, i);
      repeat (3) step(1'b1, 1'b0, 1'b0, 0);
    end
    fv_i = 1'b0;
    @(posedge pix_clk_i); #1;
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL lat_cycle0: got %b expected 0", frame_done); end
    @(posedge pix_clk_i); #1;
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL lat_cycle1: got %b expected 0", frame_done); end
    @(posedge pix_clk_i); #1;
    checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL lat_cycle2: got %b expected 1", frame_done); end
    @(posedge pix_clk_i); #1;
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL lat_cycle3: got %b expected 0", frame_done); end
    checks++; if (last_pix_cnt !== 16'd8) begin errors++; $display("FAIL dv_last_pix: got %0d expected 8", last_pix_cnt); end
    checks++; if (checksum !== 32'd224) begin errors++; $display("FAIL dv_checksum: got %0d expected 224", checksum); end
    checks++; if (err !== 4'b0000 || last_line_cnt !== 16'd4) begin errors++; $display("FAIL dv_err_lines: got err=%b lines=%0d expected 0000/4", err, last_line_cnt); end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_short_line();
    test_fv_drop();
    test_long_even();
    test_reset_mid_frame();
    test_lv_outside_fv();
    test_dvalid_gaps();
    repeat (3) step(1'b0, 1'b0, 1'b0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
